// File: rtl/mips32_mem_arbiter_pkg.sv
// Shared types and constants for the MIPS32 unified-memory arbiter.
package mips32_mem_pkg;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_DATA  = 2'd1,
    RESP_FETCH = 2'd2
  } resp_id_e;

  localparam int MEM_ADDR_W     = 10;
  localparam int STARVE_MAX_DEF = 3;

  // True when a word address lies beyond the implemented memory depth.
  function automatic logic addr_oor(input logic [31:0] addr, input int aw);
    return (addr >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter view.
interface mips32_mem_arbiter_if #(parameter int ADDR_W = 10);

  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_flush;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_mem_arbiter_starve_ctr.sv
// Saturating fetch-starvation counter; at_max_o forces fetch to win the next tie.
module mips32_starve_ctr #(
  parameter int MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] cnt_o,
  output logic       at_max_o
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = 4'd0;
    else if (inc_i && (cnt_q != MAX_C))
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares one synchronous single-port memory between instruction fetch and the
// MEM stage; data is favoured, with a starvation guard for fetch.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  mips32_mem_arbiter_if.slave  bus
);

  logic        f_ok, f_win, d_win, any_win, oor, starve_at_max;
  logic [31:0] sel_addr;
  logic [3:0]  starve_cnt;

  resp_id_e    resp_id_q, resp_id_d;
  logic        resp_zero_q, resp_zero_d;
  logic [31:0] f_hold_q, d_hold_q, rdata_cur;

  // Grants are gated by rst_n so nothing reaches the memory while in reset.
  always_comb begin
    f_ok  = bus.f_req & ~bus.f_flush;
    f_win = 1'b0;
    d_win = 1'b0;
    if (rst_n) begin
      if (f_ok && bus.d_req) begin
        if (starve_at_max) f_win = 1'b1;
        else               d_win = 1'b1;
      end else if (f_ok) begin
        f_win = 1'b1;
      end else if (bus.d_req) begin
        d_win = 1'b1;
      end
    end
  end

  assign any_win  = f_win | d_win;
  assign sel_addr = f_win ? bus.f_addr : bus.d_addr;
  assign oor      = any_win & addr_oor(sel_addr, ADDR_W);

  assign bus.f_gnt     = f_win;
  assign bus.d_gnt     = d_win;
  assign bus.d_err     = d_win & oor;
  assign bus.mem_en    = any_win & ~oor;
  assign bus.mem_we    = d_win & bus.d_we & ~oor;
  assign bus.mem_addr  = any_win ? sel_addr[ADDR_W-1:0] : '0;
  assign bus.mem_wdata = (d_win & bus.d_we) ? bus.d_wdata : 32'd0;

  mips32_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk      (clk1),
    .rst_n    (rst_n),
    .inc_i    (bus.f_req & ~f_win),
    .clr_i    (f_win | ~bus.f_req),
    .cnt_o    (starve_cnt),
    .at_max_o (starve_at_max)
  );

  // Response tag for the access granted this cycle; stores return nothing.
  always_comb begin
    resp_id_d   = RESP_NONE;
    resp_zero_d = 1'b0;
    if (f_win && !bus.f_flush) begin
      resp_id_d   = RESP_FETCH;
      resp_zero_d = oor;
    end else if (d_win && !bus.d_we) begin
      resp_id_d   = RESP_DATA;
      resp_zero_d = oor;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      resp_id_q   <= RESP_NONE;
      resp_zero_q <= 1'b0;
      f_hold_q    <= 32'd0;
      d_hold_q    <= 32'd0;
    end else begin
      resp_id_q   <= resp_id_d;
      resp_zero_q <= resp_zero_d;
      if (resp_id_q == RESP_FETCH) f_hold_q <= rdata_cur;
      if (resp_id_q == RESP_DATA)  d_hold_q <= rdata_cur;
    end
  end

  assign rdata_cur    = resp_zero_q ? 32'd0 : bus.mem_rdata;
  assign bus.f_rvalid = (resp_id_q == RESP_FETCH);
  assign bus.d_rvalid = (resp_id_q == RESP_DATA);
  assign bus.f_rdata  = bus.f_rvalid ? rdata_cur : f_hold_q;
  assign bus.d_rdata  = bus.d_rvalid ? rdata_cur : d_hold_q;

  logic unused_cnt;
  assign unused_cnt = ^starve_cnt;

endmodule
